ula_resultado_bcd: RTL and testbench
====================================

// Module: ula_resultado_bcd
// PURPOSE
//  Downstream stage of the 8-bit add/sub ULA: captures its two's-complement result
//  S and sign flag sinal, converts the magnitude to packed BCD, and holds sign and
//  digits for the display logic.
//  Sequential double-dabble: one shift/add-3 iteration per clock.
// PARAMETERS
//  WIDTH   8  width of S; two's complement; legal range 2..16
//  DIGITS  3  BCD digits out; must satisfy 10^DIGITS > 2^(WIDTH-1)
// PORTS
//  clk       in   1           single clock, rising edge
//  rst_n     in   1           synchronous reset, active-low
//  S         in   WIDTH       ULA result, two's complement
//  sinal     in   1           ULA sign flag (= S[WIDTH-1]); 1 = negative
//  inicio    in   1           start request, sampled each rising edge
//  ocupado   out  1           busy: high in CONV and FIM states
//  pronto    out  1           one-cycle pulse: bcd/negativo just updated
//  negativo  out  1           held sign of last converted result
//  bcd       out  4*DIGITS    held BCD magnitude; digit 0 = bcd[3:0] (units)
// BEHAVIOUR
//  Reset: rst_n low at an edge -> state IDLE; ocupado, pronto, negativo = 0;
//   bcd = 0; internal shift/counter regs = 0. Mid-conversion reset aborts the
//   conversion; no pronto pulse for it.
//  FSM: IDLE -> CONV -> FIM -> IDLE.
//   IDLE: on edge with inicio=1, latch mag = sinal ? (~S+1) : S (WIDTH-bit unsigned;
//    -2^(WIDTH-1) yields 2^(WIDTH-1), no overflow); latch neg_r = sinal; clear the
//    BCD accumulator; cnt = 0; go CONV. inicio=0: stay IDLE.
//   CONV: each edge: every BCD digit >= 5 gets +3, then {acc,mag} shifts left 1;
//    cnt++. On the edge where cnt == WIDTH-1 (the WIDTH-th iteration) load bcd and
//    negativo from the final accumulator / neg_r; go FIM.
//   FIM: pronto=1, ocupado=1 for exactly one cycle; next edge -> IDLE.
//  Latency: inicio seen at edge E0 -> bcd/negativo valid and pronto high after edge
//   E(WIDTH); back at IDLE after E(WIDTH+1). Throughput: one conversion per WIDTH+2 clocks.
//  inicio while ocupado=1 (CONV or FIM): ignored, not queued.
//  S/sinal are sampled only at the accepting edge; later changes have no effect.
//  bcd/negativo hold their value between conversions; they change only at the
//   final CONV edge or on reset.
//  Zero result: negativo = 0, bcd = 0. sinal=1 with S[WIDTH-1]=0 is an illegal input;
//   its output is not required to match any value.
// CONFIGURATION
//  Macro ULA_RESULTADO_SEG7_EN:
//   defined: adds outputs seg [7*DIGITS-1:0] and seg_sinal (1). seg holds one
//    7-segment code per digit, active-high, bit order gfedcba (0=7'h3F, 1=7'h06,
//    8=7'h7F). Leading zero digits are blanked to 7'h00; the units digit is never
//    blanked. seg_sinal = negativo (drives segment g of the sign digit). seg and
//    seg_sinal are registered and update on the same edge as bcd. Reset value is
//    0 for both.
//   undefined: seg/seg_sinal ports and decode logic absent. All other behaviour is
//    identical.
// TESTING
//  1 S=8'h05,sinal=0,inicio pulse -> pronto 8 clks after accept; bcd=12'h005, neg=0
//  2 S=8'h80,sinal=1 -> bcd=12'h128, negativo=1; S=8'h7F,sinal=0 -> bcd=12'h127
//  3 S=8'hFF,sinal=1 -> bcd=12'h001, negativo=1; S=8'h00 -> bcd=12'h000, neg=0
//  4 inicio held high 20 clks with S=8'h0A -> new conversion every 10 clks;
//    pronto one cycle each time; bcd=12'h010; S changed mid-CONV has no effect
//  5 rst_n low 1 clk at 4th CONV cycle -> all outputs 0 next cycle, no pronto;
//    fresh inicio then converts normally
//  6 SEG7_EN: S=8'hF9 (-7) -> seg={7'h00,7'h00,7'h07}, seg_sinal=1; S=8'h64 (100)
//    -> seg={7'h06,7'h3F,7'h3F}

Source files
------------

// File: rtl/ula_resultado_bcd.sv
// Result stage of the 8-bit add/sub ULA: sign/magnitude capture and sequential
// double-dabble to packed BCD. Optional 7-segment decode: ULA_RESULTADO_SEG7_EN.
module ula_resultado_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      S,
  input  logic                  sinal,
  input  logic                  inicio,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  negativo,
  output logic [4*DIGITS-1:0]   bcd
`ifdef ULA_RESULTADO_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  seg_sinal
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_FIM} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_mag;
  logic [BW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic [BW-1:0]    r_bcd;
  logic             r_negativo;
  logic [WIDTH-1:0] w_mag_in;
  logic [BW-1:0]    w_acc_adj;
  logic [BW-1:0]    w_acc_nxt;
  logic [WIDTH-1:0] w_mag_nxt;
  logic             w_last;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    add3 = a;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5)
        add3[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
  endfunction

  // Magnitude is WIDTH-bit unsigned, so the most negative input maps to 2^(WIDTH-1).
  assign w_mag_in  = sinal ? (~S + 1'b1) : S;
  assign w_acc_adj = add3(r_acc);
  assign w_acc_nxt = {w_acc_adj[BW-2:0], r_mag[WIDTH-1]};
  assign w_mag_nxt = {r_mag[WIDTH-2:0], 1'b0};
  assign w_last    = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (inicio) w_state_nxt = ST_CONV;
      ST_CONV: if (w_last) w_state_nxt = ST_FIM;
      ST_FIM:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef ULA_RESULTADO_SEG7_EN
  logic [7*DIGITS-1:0] r_seg;
  logic                r_seg_sinal;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Leading zeros are blanked scanning from the top digit; units always shown.
  function automatic logic [7*DIGITS-1:0] seg_blank(input logic [BW-1:0] a);
    logic       lead;
    logic [3:0] dig;
    seg_blank = '0;
    lead      = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      dig = a[4*d +: 4];
      if (lead && (dig == 4'd0) && (d != 0)) begin
        seg_blank[7*d +: 7] = 7'h00;
      end else begin
        lead                = 1'b0;
        seg_blank[7*d +: 7] = seg7(dig);
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg       <= '0;
      r_seg_sinal <= 1'b0;
    end else if ((r_state == ST_CONV) && w_last) begin
      r_seg       <= seg_blank(w_acc_nxt);
      r_seg_sinal <= r_neg;
    end
  end

  assign seg       = r_seg;
  assign seg_sinal = r_seg_sinal;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mag      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_bcd      <= '0;
      r_negativo <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inicio) begin
            r_mag <= w_mag_in;
            r_neg <= sinal;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ST_CONV: begin
          r_acc <= w_acc_nxt;
          r_mag <= w_mag_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_bcd      <= w_acc_nxt;
            r_negativo <= r_neg;
          end
        end
        default: ;
      endcase
    end
  end

  assign ocupado  = (r_state != ST_IDLE);
  assign pronto   = (r_state == ST_FIM);
  assign bcd      = r_bcd;
  assign negativo = r_negativo;

endmodule

// File: tb/tb_ula_resultado_bcd.sv
// Directed bench for ula_resultado_bcd: vector table plus hold/overlap and
// mid-conversion reset sequences. Seg checks active with ULA_RESULTADO_SEG7_EN.
module tb_ula_resultado_bcd;

  logic        clk;
  logic        rst_n;
  logic [7:0]  S;
  logic        sinal;
  logic        inicio;
  logic        ocupado;
  logic        pronto;
  logic        negativo;
  logic [11:0] bcd;
`ifdef ULA_RESULTADO_SEG7_EN
  logic [20:0] seg;
  logic        seg_sinal;
`endif

  int total = 0;
  int bad   = 0;

  ula_resultado_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .S        (S),
    .sinal    (sinal),
    .inicio   (inicio),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .negativo (negativo),
    .bcd      (bcd)
`ifdef ULA_RESULTADO_SEG7_EN
    ,
    .seg      (seg),
    .seg_sinal(seg_sinal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  s;
    logic        sg;
    logic [11:0] exp_bcd;
    logic        exp_neg;
    logic [20:0] exp_seg;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_conv(input logic [7:0] s, input logic sg, input logic [11:0] eb,
                          input logic en, input logic [20:0] es);
    int n;
    @(negedge clk);
    S = s; sinal = sg; inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    S = ~s; sinal = ~sg;
    chk("busy_after_accept", ocupado, 1);
    n = 0;
    while (!pronto && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 8);
    chk("bcd", bcd, eb);
    chk("negativo", negativo, en);
`ifdef ULA_RESULTADO_SEG7_EN
    chk("seg", seg, es);
    chk("seg_sinal", seg_sinal, en);
`else
    if (es == 21'h1FFFFF) $display("note: unused seg vector");
`endif
    @(posedge clk);
    #1;
    chk("pronto_one_cycle", pronto, 0);
    chk("idle_after_fim", ocupado, 0);
  endtask

  initial begin
    vecs[0] = '{8'h05, 1'b0, 12'h005, 1'b0, {7'h00, 7'h00, 7'h6D}};
    vecs[1] = '{8'h80, 1'b1, 12'h128, 1'b1, {7'h06, 7'h5B, 7'h7F}};
    vecs[2] = '{8'h7F, 1'b0, 12'h127, 1'b0, {7'h06, 7'h5B, 7'h07}};
    vecs[3] = '{8'hFF, 1'b1, 12'h001, 1'b1, {7'h00, 7'h00, 7'h06}};
    vecs[4] = '{8'h00, 1'b0, 12'h000, 1'b0, {7'h00, 7'h00, 7'h3F}};
    vecs[5] = '{8'h0A, 1'b0, 12'h010, 1'b0, {7'h00, 7'h06, 7'h3F}};
    vecs[6] = '{8'hF9, 1'b1, 12'h007, 1'b1, {7'h00, 7'h00, 7'h07}};
    vecs[7] = '{8'h64, 1'b0, 12'h100, 1'b0, {7'h06, 7'h3F, 7'h3F}};
    vecs[8] = '{8'h63, 1'b0, 12'h099, 1'b0, {7'h00, 7'h6F, 7'h6F}};
    vecs[9] = '{8'hC8, 1'b1, 12'h056, 1'b1, {7'h00, 7'h6D, 7'h7D}};

    rst_n = 1'b0; S = 8'h00; sinal = 1'b0; inicio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_negativo", negativo, 0);
    chk("rst_bcd", bcd, 0);
`ifdef ULA_RESULTADO_SEG7_EN
    chk("rst_seg", seg, 0);
    chk("rst_seg_sinal", seg_sinal, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++)
      run_conv(vecs[i].s, vecs[i].sg, vecs[i].exp_bcd, vecs[i].exp_neg, vecs[i].exp_seg);

    // outputs hold between conversions
    repeat (5) @(posedge clk);
    #1;
    chk("hold_bcd", bcd, 12'h056);
    chk("hold_neg", negativo, 1);

    // inicio held 20 edges: accepts at edges 0 and 10, pronto at 8 and 18
    @(negedge clk);
    S = 8'h0A; sinal = 1'b0; inicio = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) S = 8'h55;
      if (k == 7) S = 8'h0A;
      if (k == 19) inicio = 1'b0;
      chk($sformatf("held_pronto_k%0d", k), pronto, (k == 8 || k == 18) ? 1 : 0);
      if (k == 8 || k == 18) begin
        chk("held_bcd", bcd, 12'h010);
        chk("held_neg", negativo, 0);
      end
    end

    // mid-conversion reset
    run_conv(8'hFF, 1'b1, 12'h001, 1'b1, {7'h00, 7'h00, 7'h06});
    @(negedge clk);
    S = 8'h7F; sinal = 1'b0; inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_ocupado", ocupado, 0);
    chk("abort_pronto", pronto, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_neg", negativo, 0);
`ifdef ULA_RESULTADO_SEG7_EN
    chk("abort_seg", seg, 0);
    chk("abort_seg_sinal", seg_sinal, 0);
`endif
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (pronto) pulses++;
      end
      chk("abort_no_pronto", pulses, 0);
    end
    run_conv(8'h7F, 1'b0, 12'h127, 1'b0, {7'h06, 7'h5B, 7'h07});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
